// File: rtl/muldiv_seq_if.sv
// Bundle of the request/response and shared-ALU signals between the execute
// stage (master) and the multiply/divide sequencer (slave).
interface muldiv_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;

  modport master (
    output start, op, rs1, rs2, alu_result,
    input  busy, done, result, alu_a, alu_b, alu_control
  );

  modport slave (
    input  start, op, rs1, rs2, alu_result,
    output busy, done, result, alu_a, alu_b, alu_control
  );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer. Borrows the shared
// 32-bit ALU while running: shift-add multiply (ADD) or restoring divide
// (SUB), one ALU operation per cycle, 32 iterations. RUN lasts 33 cycles:
// 32 iteration cycles followed by one cycle that commits the result.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_seq_if.slave bus
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  cnt;
  logic        iter_done;
  logic [1:0]  op_q;
  // hi doubles as the partial remainder, lo as the quotient shift register,
  // mcand as the divisor; multiply and divide never run at the same time.
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mcand;
  logic [31:0] result_q;

  logic        is_div;
  logic [31:0] shifted;
  logic        carry;
  logic [31:0] sum;
  logic        ok;
  logic [31:0] hi_next;
  logic [31:0] lo_next;
  logic [31:0] result_sel;

  assign is_div  = op_q[1];
  assign shifted = {hi[30:0], lo[31]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state, status flags and the ALU operand drive.
  always_comb begin
    state_next      = state;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.alu_a       = 32'd0;
    bus.alu_b       = 32'd0;
    bus.alu_control = ALU_ADD;
    case (state)
      IDLE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        bus.busy        = 1'b1;
        bus.alu_a       = is_div ? shifted : hi;
        bus.alu_b       = mcand;
        bus.alu_control = is_div ? ALU_SUB : ALU_ADD;
        if (iter_done) state_next = DONE;
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One multiply or divide step; the 33-bit remainder case is covered by hi[31].
  always_comb begin
    carry   = 1'b0;
    sum     = hi;
    ok      = 1'b0;
    hi_next = hi;
    lo_next = lo;
    if (is_div) begin
      ok      = hi[31] | (shifted >= mcand);
      hi_next = ok ? bus.alu_result : shifted;
      lo_next = {lo[30:0], ok};
    end else begin
      if (lo[0]) begin
        carry = bus.alu_result < hi;
        sum   = bus.alu_result;
      end
      hi_next = {carry, sum[31:1]};
      lo_next = {sum[0], lo[31:1]};
    end
  end

  // Pick the architectural result for the latched op.
  always_comb begin
    result_sel = lo;
    case (op_q)
      2'b00: result_sel = lo;
      2'b01: result_sel = hi;
      2'b10: result_sel = lo;
      2'b11: result_sel = hi;
      default: result_sel = lo;
    endcase
  end

  // Operand capture on accept, iteration while running, result commit at the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 5'd0;
      iter_done <= 1'b0;
      op_q      <= 2'b00;
      hi        <= 32'd0;
      lo        <= 32'd0;
      mcand     <= 32'd0;
      result_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q      <= bus.op;
            cnt       <= 5'd0;
            iter_done <= 1'b0;
            hi        <= 32'd0;
            lo        <= bus.rs1;
            mcand     <= bus.rs2;
          end
        end
        RUN: begin
          if (!iter_done) begin
            hi <= hi_next;
            lo <= lo_next;
            if (cnt == 5'd31) iter_done <= 1'b1;
            else              cnt <= cnt + 5'd1;
          end else begin
            result_q <= result_sel;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and randomized check of muldiv_seq against an arithmetic reference.
module tb_muldiv_seq;

  logic clk;
  logic rst_n;
  int   nChecks;
  int   nFails;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared ALU behaviour seen by the sequencer.
  assign bus.alu_result = (bus.alu_control == 4'b0010) ? bus.alu_a + bus.alu_b :
                          (bus.alu_control == 4'b0110) ? bus.alu_a - bus.alu_b : 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] refModel(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFFFFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one op from an IDLE negedge; optionally pulses a stray DIVU start at cycle pulseAt.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input int pulseAt);
    logic [31:0] expRes;
    logic [31:0] prevRes;
    int          lat;
    int          busyCnt;
    expRes  = refModel(o, a, b);
    prevRes = bus.result;
    checkOutput("idle_alu_a", bus.alu_a, 32'd0);
    checkOutput("idle_alu_ctl", {28'd0, bus.alu_control}, 32'd2);
    bus.start = 1'b1;
    bus.op    = o;
    bus.rs1   = a;
    bus.rs2   = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.rs1   = $urandom;
    bus.rs2   = $urandom;
    checkOutput("run_busy", {31'd0, bus.busy}, 32'd1);
    checkOutput("run_done", {31'd0, bus.done}, 32'd0);
    checkOutput("run_result_held", bus.result, prevRes);
    checkOutput("run_alu_ctl", {28'd0, bus.alu_control}, o[1] ? 32'd6 : 32'd2);
    checkOutput("run_alu_a", bus.alu_a, o[1] ? {31'd0, a[31]} : 32'd0);
    checkOutput("run_alu_b", bus.alu_b, b);
    busyCnt = 1;
    lat     = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
      if (lat == pulseAt) begin
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.rs1   = 32'd9;
        bus.rs2   = 32'd3;
      end
      if (bus.busy) busyCnt++;
      if (bus.done) break;
    end
    checkOutput("latency", lat, 33);
    checkOutput("result", bus.result, expRes);
    checkOutput("busy_cycles", busyCnt, 34);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("post_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("post_done", {31'd0, bus.done}, 32'd0);
    checkOutput("post_result_held", bus.result, expRes);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          sawDone;
    nChecks   = 0;
    nFails    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.rs1   = 32'd0;
    bus.rs2   = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
    checkOutput("rst_result", bus.result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed ops");
    applyStimulus(2'b00, 32'd7, 32'd6, 0);
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    applyStimulus(2'b10, 32'd100, 32'd7, 0);
    applyStimulus(2'b11, 32'd100, 32'd7, 0);
    applyStimulus(2'b10, 32'hFFFFFFFF, 32'd1, 0);
    applyStimulus(2'b11, 32'hFFFFFFFF, 32'd1, 0);
    applyStimulus(2'b10, 32'h12345678, 32'd0, 0);
    applyStimulus(2'b11, 32'h12345678, 32'd0, 0);
    applyStimulus(2'b00, 32'd3, 32'd5, 10);
    applyStimulus(2'b10, 32'd9, 32'd3, 0);

    $display("[TB] reset during RUN");
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.rs1   = 32'd4;
    bus.rs2   = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("midrst_done", {31'd0, bus.done}, 32'd0);
    checkOutput("midrst_result", bus.result, 32'd0);
    checkOutput("midrst_alu_a", bus.alu_a, 32'd0);
    checkOutput("midrst_alu_b", bus.alu_b, 32'd0);
    checkOutput("midrst_alu_ctl", {28'd0, bus.alu_control}, 32'd2);
    @(negedge clk);
    rst_n   = 1'b1;
    sawDone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) sawDone++;
    end
    checkOutput("midrst_no_done", sawDone, 0);
    applyStimulus(2'b00, 32'd2, 32'd3, 0);

    $display("[TB] randomized ops");
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0:       ra = 32'd0;
        1:       ra = 32'd1;
        2:       ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFFFFFF;
        3:       rb = 32'($urandom_range(2, 255));
        default: rb = $urandom;
      endcase
      applyStimulus(2'(i % 4), ra, rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
